axil_master: RTL and testbench
==============================

# axil_master

AXI4-Lite single-outstanding initiator for the PL side. A simple command/response port on the fabric side is converted into AXI-Lite AW/W/B or AR/R transactions on the master side. It drives the register slaves on the GP-port bus from fabric logic, for self-test and DMA-less configuration, and reports a timeout when a slave never responds.

## Interface
- ADDR_W, 32: address width, cmd and AR/AW.
- TIMEOUT, 1024: cycles from command accept to B/R handshake before a timeout is reported; 0 disables. Range 0..65535.
- PROT, 3'b000: constant driven on awprot/arprot.

- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte strobes.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP; 2'b10 on timeout.
- rsp_timeout  out  1  response was produced by the timeout.
- m_awaddr, m_awprot, m_awvalid / m_awready  out, out, out / in  ADDR_W, 3, 1 / 1.
- m_wdata, m_wstrb, m_wvalid / m_wready  out, out, out / in  32, 4, 1 / 1.
- m_bresp, m_bvalid / m_bready  in, in / out  2, 1 / 1.
- m_araddr, m_arprot, m_arvalid / m_arready  out, out, out / in  ADDR_W, 3, 1 / 1.
- m_rdata, m_rresp, m_rvalid / m_rready  in, in, in / out  32, 2, 1 / 1.

## Operation
- States: IDLE, WRITE (AW and W pending), WRESP, READ (AR pending), RDATA, RESP, DRAIN.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/data/strb and go to WRITE or READ. The timeout counter is cleared.
- WRITE: awvalid and wvalid both asserted. Each deasserts independently after its own handshake. Go to WRESP once both channels have handshaken (same cycle or any order).
- WRESP: bready=1. On bvalid, capture bresp and go to RESP.
- READ: arvalid=1 until arready, then go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata/rresp and go to RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready, then go to IDLE.
- Timeout: the counter increments every cycle in WRITE/WRESP/READ/RDATA and saturates at 16 bits. When it reaches TIMEOUT:
  - post rsp_valid with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0;
  - pending AXI valids stay asserted, since AXI forbids withdrawal;
  - the FSM goes to DRAIN and completes the bus transaction;
  - the late B/R is discarded;
  - return to IDLE only when the bus is done and the response has been consumed.
- rsp_timeout=0 and rresp/bresp pass through unmodified on normal completion.
- Reset mid-transaction forces IDLE immediately, all valids to 0, and abandons any bus transaction.

## Timing
- Reset values: cmd_ready=0 during reset, 1 the first cycle after. All m_*valid, bready, rready, rsp_valid, rsp_timeout = 0. rsp_rdata, rsp_resp, and the addr/data outputs = 0.
- All outputs are registered except cmd_ready, which is decoded from the state register.
- awvalid/wvalid/arvalid rise the cycle after cmd accept.
- Zero-wait slave, write: accept at T, AW+W handshake at T+1, bvalid at T+2, rsp_valid at T+3.
- Zero-wait slave, read: accept at T, AR at T+1, rvalid at T+2, rsp_valid at T+3.
- Back-to-back: a new command is accepted the cycle after the rsp handshake. Throughput is 1 transaction per 4 cycles minimum.
- Timeout fires in the cycle the count equals TIMEOUT; rsp_valid rises the next cycle.
- If B/R and the timeout coincide, B/R wins and no timeout is reported.

## Structure
- Shared package axil_pkg:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - the state enum;
  - the timeout counter width of 16.
- One sub-module is natural: axil_timeout (load/enable/saturating counter with a `hit` flag), reusable by the slave side.

## Test plan
- Write 0x1234_5678, strb 4'hF, to 0x0000_0010 with a zero-wait slave -> awaddr=0x10, wdata=0x12345678, rsp_valid at T+3, rsp_resp=0, rsp_timeout=0.
- Read 0x4 with a slave returning rdata=0xDEAD_BEEF, rresp=2'b10 after 5 wait cycles -> rsp_rdata=0xDEADBEEF, rsp_resp=2'b10, rsp_timeout=0.
- Write where wready precedes awready by 3 cycles -> wvalid drops after its handshake, awvalid is held, bready is asserted only after both.
- TIMEOUT=16 with a slave that never asserts arready -> rsp_valid with rsp_resp=2'b10, rsp_timeout=1 at accept+17. arvalid stays 1 and cmd_ready stays 0 until the slave completes; the late data is not reported.
- rsp_ready held low for 10 cycles -> rsp fields stable, cmd_ready=0 throughout. A new cmd is accepted the cycle after rsp_ready.
- Reset asserted while in WRESP -> next cycle all valids/readies are 0 and the FSM is in IDLE; the following write completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite master and its helpers:
// response codes, FSM state encoding and the timeout counter width.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    RESP,
    DRAIN
  } state_t;

endpackage

// File: rtl/axil_master_if.sv
// AXI4-Lite bus bundle: five channels, with master and slave views.
interface axil_master_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_timeout.sv
// Saturating cycle counter with a compare flag; a limit of zero never hits.
// Asserting clear and enable together restarts the count at one.
module axil_timeout import axil_pkg::*; #(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] count;
  logic [W-1:0] count_n;

  always_comb begin
    count_n = clear ? '0 : count;
    if (enable && count_n != '1) count_n = count_n + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else       count <= count_n;
  end

  assign hit = (limit != '0) && (count == limit);

endmodule

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: turns a command/response port
// into AW/W/B or AR/R transactions, with a response timeout.
module axil_master import axil_pkg::*; #(
  parameter int         ADDR_W  = 32,
  parameter int         TIMEOUT = 1024,
  parameter logic [2:0] PROT    = 3'b000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  axil_master_if.master     m
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

  state_t            state, state_n;
  logic              write_q, write_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [3:0]        wstrb_q, wstrb_n;
  logic              aw_q, aw_n, w_q, w_n, ar_q, ar_n, b_q, b_n, r_q, r_n;
  logic              rsp_valid_n, rsp_timeout_n;
  logic [31:0]       rsp_rdata_n;
  logic [1:0]        rsp_resp_n;
  logic              done_q, done_n;
  logic              accept, busy, hit, fire;
  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = state inside {WRITE, WRESP, READ, RDATA};
  assign aw_hs     = aw_q && m.awready;
  assign w_hs      = w_q && m.wready;
  assign ar_hs     = ar_q && m.arready;
  assign b_hs      = b_q && m.bvalid;
  assign r_hs      = r_q && m.rvalid;
  assign rsp_hs    = rsp_valid && rsp_ready;

  axil_timeout #(.W(TIMER_W)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (accept || busy),
    .limit  (LIMIT),
    .hit    (hit)
  );

  // A B/R handshake always beats a coincident timeout; after a timeout the
  // bus transaction is still finished in DRAIN and its result discarded.
  always_comb begin
    state_n       = state;
    write_n       = write_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    wstrb_n       = wstrb_q;
    aw_n          = aw_q && !aw_hs;
    w_n           = w_q && !w_hs;
    ar_n          = ar_q && !ar_hs;
    b_n           = b_q;
    r_n           = r_q;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_resp_n    = rsp_resp;
    rsp_timeout_n = rsp_timeout;
    done_n        = done_q;
    fire          = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          write_n = cmd_write;
          addr_n  = cmd_addr;
          wdata_n = cmd_wdata;
          wstrb_n = cmd_wstrb;
          aw_n    = cmd_write;
          w_n     = cmd_write;
          ar_n    = !cmd_write;
          done_n  = 1'b0;
          state_n = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (hit) fire = 1'b1;
        else if (!aw_n && !w_n) begin
          b_n     = 1'b1;
          state_n = WRESP;
        end
      end
      WRESP: begin
        if (b_hs) begin
          b_n           = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = '0;
          rsp_resp_n    = m.bresp;
          rsp_timeout_n = 1'b0;
          state_n       = RESP;
        end else if (hit) fire = 1'b1;
      end
      READ: begin
        if (hit) fire = 1'b1;
        else if (ar_hs) begin
          r_n     = 1'b1;
          state_n = RDATA;
        end
      end
      RDATA: begin
        if (r_hs) begin
          r_n           = 1'b0;
          rsp_valid_n   = 1'b1;
          rsp_rdata_n   = m.rdata;
          rsp_resp_n    = m.rresp;
          rsp_timeout_n = 1'b0;
          state_n       = RESP;
        end else if (hit) fire = 1'b1;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      DRAIN: begin
        if (rsp_hs) rsp_valid_n = 1'b0;
        if (b_hs || r_hs) begin
          b_n    = 1'b0;
          r_n    = 1'b0;
          done_n = 1'b1;
        end else if (!done_q && !aw_n && !w_n && !ar_n) begin
          b_n = write_q;
          r_n = !write_q;
        end
        if (done_n && !rsp_valid_n) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (fire) begin
      rsp_valid_n   = 1'b1;
      rsp_rdata_n   = '0;
      rsp_resp_n    = RESP_SLVERR;
      rsp_timeout_n = 1'b1;
      state_n       = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_q        <= 1'b0;
      w_q         <= 1'b0;
      ar_q        <= 1'b0;
      b_q         <= 1'b0;
      r_q         <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      write_q     <= write_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      wstrb_q     <= wstrb_n;
      aw_q        <= aw_n;
      w_q         <= w_n;
      ar_q        <= ar_n;
      b_q         <= b_n;
      r_q         <= r_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_resp    <= rsp_resp_n;
      rsp_timeout <= rsp_timeout_n;
      done_q      <= done_n;
    end
  end

  assign m.awaddr  = addr_q;
  assign m.awprot  = PROT;
  assign m.awvalid = aw_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign m.wvalid  = w_q;
  assign m.bready  = b_q;
  assign m.araddr  = addr_q;
  assign m.arprot  = PROT;
  assign m.arvalid = ar_q;
  assign m.rready  = r_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: the bench plays the AXI slave and the
// command master, and checks outputs on the falling clock edge.
module tb_axil_master;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  int          total = 0;
  int          bad = 0;

  axil_master_if #(.ADDR_W(32)) bus ();

  axil_master #(.ADDR_W(32), .TIMEOUT(16), .PROT(3'b000)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_wstrb   (cmd_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_resp    (rsp_resp),
    .rsp_timeout (rsp_timeout),
    .m           (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    cyc(); cyc();

    // Reset values
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_valids", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid, rsp_timeout}), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_resp", 32'(rsp_resp), 32'd0);
    check("rst_addr_data", bus.awaddr | bus.araddr | bus.wdata, 32'd0);
    reset = 1'b0;
    cyc();
    check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // Zero-wait write
    bus.awready = 1'b1; bus.wready = 1'b1;
    issue(1'b1, 32'h0000_0010, 32'h1234_5678, 4'hF);
    cyc(); cmd_valid = 1'b0;
    check("wr_aw_w_valid", 32'({bus.awvalid, bus.wvalid, cmd_ready}), 32'b110);
    check("wr_awaddr", bus.awaddr, 32'h0000_0010);
    check("wr_wdata", bus.wdata, 32'h1234_5678);
    check("wr_wstrb", 32'(bus.wstrb), 32'hF);
    cyc();
    check("wr_bready", 32'({bus.awvalid, bus.wvalid, bus.bready, rsp_valid}), 32'b0010);
    bus.bvalid = 1'b1; bus.bresp = RESP_OKAY; bus.awready = 1'b0; bus.wready = 1'b0;
    cyc(); bus.bvalid = 1'b0;
    check("wr_rsp_t3", 32'({rsp_valid, rsp_timeout, rsp_resp, bus.bready}), 32'b1_0_00_0);
    check("wr_rsp_rdata", rsp_rdata, 32'd0);
    cyc();
    check("wr_rsp_done", 32'({rsp_valid, cmd_ready}), 32'b01);

    // Read with 5 wait cycles and SLVERR passed through
    bus.arready = 1'b1;
    issue(1'b0, 32'h0000_0004, 32'd0, 4'h0);
    cyc(); cmd_valid = 1'b0;
    check("rd_arvalid", 32'(bus.arvalid), 32'd1);
    check("rd_araddr", bus.araddr, 32'h0000_0004);
    cyc(); bus.arready = 1'b0;
    check("rd_rready", 32'({bus.arvalid, bus.rready}), 32'b01);
    repeat (5) cyc();
    check("rd_waiting", 32'({rsp_valid, bus.rready}), 32'b01);
    bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = RESP_SLVERR;
    cyc(); bus.rvalid = 1'b0;
    check("rd_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1_0_10);
    check("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    cyc();

    // W handshakes three cycles before AW
    bus.wready = 1'b1; bus.awready = 1'b0;
    issue(1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'h3);
    cyc(); cmd_valid = 1'b0;
    check("ord_both_valid", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'b110);
    cyc(); bus.wready = 1'b0;
    check("ord_w_dropped", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'b100);
    cyc();
    check("ord_aw_held1", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'b100);
    cyc();
    check("ord_aw_held2", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'b100);
    bus.awready = 1'b1;
    cyc(); bus.awready = 1'b0;
    check("ord_bready", 32'({bus.awvalid, bus.wvalid, bus.bready}), 32'b001);
    bus.bvalid = 1'b1; bus.bresp = RESP_EXOKAY;
    cyc(); bus.bvalid = 1'b0;
    check("ord_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1_0_01);
    cyc();

    // Timeout on a read whose AR is never accepted (TIMEOUT=16)
    bus.arready = 1'b0;
    issue(1'b0, 32'h0000_0008, 32'd0, 4'h0);
    cyc(); cmd_valid = 1'b0;
    repeat (15) cyc();
    check("to_not_yet", 32'({rsp_valid, bus.arvalid}), 32'b01);
    cyc();
    check("to_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1_1_10);
    check("to_rdata", rsp_rdata, 32'd0);
    check("to_ar_held", 32'({bus.arvalid, cmd_ready}), 32'b10);
    cyc();
    check("to_drain", 32'({rsp_valid, bus.arvalid, cmd_ready}), 32'b010);
    cyc(); cyc();
    check("to_drain_hold", 32'({bus.arvalid, cmd_ready}), 32'b10);
    bus.arready = 1'b1;
    cyc(); bus.arready = 1'b0;
    check("to_drain_rready", 32'({bus.arvalid, bus.rready, cmd_ready}), 32'b010);
    bus.rvalid = 1'b1; bus.rdata = 32'h1111_2222; bus.rresp = RESP_OKAY;
    cyc(); bus.rvalid = 1'b0;
    check("to_late_dropped", 32'({rsp_valid, bus.rready, cmd_ready}), 32'b001);

    // Response back-pressure: rsp_ready low for 10 cycles
    rsp_ready = 1'b0; bus.awready = 1'b1; bus.wready = 1'b1;
    issue(1'b1, 32'h0000_0040, 32'h55AA_55AA, 4'hC);
    cyc(); cmd_valid = 1'b0;
    cyc(); bus.awready = 1'b0; bus.wready = 1'b0;
    bus.bvalid = 1'b1; bus.bresp = RESP_DECERR;
    cyc(); bus.bvalid = 1'b0;
    check("bp_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1_0_11);
    issue(1'b0, 32'h0000_0044, 32'd0, 4'h0);
    bus.arready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("bp_hold", 32'({rsp_valid, rsp_timeout, rsp_resp, cmd_ready, bus.arvalid}), 32'b1_0_11_0_0);
    end
    rsp_ready = 1'b1;
    cyc();
    check("bp_released", 32'({rsp_valid, cmd_ready}), 32'b01);
    cyc(); cmd_valid = 1'b0;
    check("bp_next_accepted", 32'(bus.arvalid), 32'd1);
    check("bp_next_araddr", bus.araddr, 32'h0000_0044);
    cyc(); bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_F00D; bus.rresp = RESP_OKAY;
    cyc(); bus.rvalid = 1'b0;
    check("bp_next_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1_0_00);
    check("bp_next_rdata", rsp_rdata, 32'hCAFE_F00D);
    cyc();

    // Reset while waiting for B, then a clean write
    bus.awready = 1'b1; bus.wready = 1'b1;
    issue(1'b1, 32'h0000_0050, 32'h0102_0304, 4'hF);
    cyc(); cmd_valid = 1'b0;
    cyc();
    check("rm_in_wresp", 32'(bus.bready), 32'd1);
    reset = 1'b1; bus.awready = 1'b0; bus.wready = 1'b0;
    cyc();
    check("rm_cleared", 32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid, cmd_ready}), 32'd0);
    reset = 1'b0;
    #1;
    check("rm_idle", 32'(cmd_ready), 32'd1);
    bus.awready = 1'b1; bus.wready = 1'b1;
    issue(1'b1, 32'h0000_0030, 32'h0BAD_CAFE, 4'hF);
    cyc(); cmd_valid = 1'b0;
    check("rm_wr_valid", 32'({bus.awvalid, bus.wvalid}), 32'b11);
    check("rm_wr_awaddr", bus.awaddr, 32'h0000_0030);
    check("rm_wr_wdata", bus.wdata, 32'h0BAD_CAFE);
    cyc(); bus.awready = 1'b0; bus.wready = 1'b0;
    check("rm_wr_bready", 32'(bus.bready), 32'd1);
    bus.bvalid = 1'b1; bus.bresp = RESP_OKAY;
    cyc(); bus.bvalid = 1'b0;
    check("rm_wr_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1_0_00);
    cyc();
    check("rm_wr_done", 32'({rsp_valid, cmd_ready}), 32'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
